// File: rtl/alu_bitserial_seq_pkg.sv
// Shared definitions for the bit-serial execute unit:
// opcodes, sequencer states and the arithmetic-op test.
package alu_bitserial_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NOTA = 3'b010;
  localparam logic [2:0] OP_NOTB = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_ANDN = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return op[2:1] == 2'b00;
  endfunction

endpackage

// File: rtl/alu_bitserial_seq_slice.sv
// 1-bit ALU slice (ALUslice): one result bit plus carry-out.
// The carry chain always runs; only add/sub use its result.
module alu_bitserial_seq_slice
  import alu_bitserial_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       ci,
  output logic       f,
  output logic       co
);

  logic b_eff;

  // op[0] inverts b for subtract
  assign b_eff = op[0] ? ~b : b;
  assign co    = (a & b_eff) | (a & ci) | (b_eff & ci);

  always_comb begin
    f = 1'b0;
    unique case (op)
      OP_ADD,
      OP_SUB:  f = a ^ b_eff ^ ci;
      OP_NOTA: f = ~a;
      OP_NOTB: f = ~b;
      OP_OR:   f = a | b;
      OP_ORN:  f = a | ~b;
      OP_AND:  f = a & b;
      OP_ANDN: f = a & ~b;
    endcase
  end

endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial execute unit: one slice, LSB-first, W cycles
// per operation, result and flags presented with done.
module alu_bitserial_seq
  import alu_bitserial_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int CW = $clog2(W);

  state_t         state;
  state_t         state_nxt;
  logic [2:0]     op_r;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [CW-1:0]  cnt;
  logic           carry_r;
  logic           f;
  logic           co;
  logic           last;
  logic [W-1:0]   res_nxt;

  assign last    = cnt == CW'(W - 1);
  assign res_nxt = {f, result[W-1:1]};

  alu_bitserial_seq_slice u_slice (
    .op (op_r),
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_r),
    .f  (f),
    .co (co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= OP_ADD;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      carry_r <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      op_r    <= op;
      a_sh    <= a;
      b_sh    <= b;
      cnt     <= '0;
      carry_r <= op == OP_SUB;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else if (state == ST_RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      carry_r <= co;
      result  <= res_nxt;
      if (!last) cnt <= cnt + 1'b1;
      // carry_r here is the carry into the MSB
      if (last) begin
        cout <= is_arith(op_r) & co;
        ovf  <= is_arith(op_r) & (carry_r ^ co);
        zero <= res_nxt == '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Self-checking bench for alu_bitserial_seq (W=8):
// directed cases, protocol corner cases and random ops.
module tb_alu_bitserial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_bitserial_seq #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: {result, cout, ovf}
  function automatic logic [9:0] model(input logic [2:0] o,
                                       input logic [7:0] x,
                                       input logic [7:0] y);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    logic       v;
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'd0: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[7:0];
        c = s[8];
        v = (x[7] == y[7]) && (r[7] != x[7]);
      end
      3'd1: begin
        s = {1'b0, x} + {1'b0, ~y} + 9'd1;
        r = s[7:0];
        c = s[8];
        v = (x[7] != y[7]) && (r[7] != x[7]);
      end
      3'd2: r = ~x;
      3'd3: r = ~y;
      3'd4: r = x | y;
      3'd5: r = x | ~y;
      3'd6: r = x & y;
      default: r = x & ~y;
    endcase
    return {r, c, v};
  endfunction

  // one operation from IDLE; glitch >= 0 pulses start mid-run
  task automatic run_op(input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input int glitch);
    logic [9:0] m;
    int n;
    m = model(o, x, y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom);
    a = 8'($urandom);
    b = 8'($urandom);
    chk("busy_rise", busy, 1);
    n = 0;
    for (int k = 0; k < W + 6 && !done; k++) begin
      if (k == glitch) begin
        start = 1'b1;
        op = 3'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    chk("latency", n, W);
    chk("result", result, m[9:2]);
    chk("cout", cout, m[1]);
    chk("ovf", ovf, m[0]);
    chk("zero", zero, m[9:2] == 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("done_width", done, 0);
    chk("busy_fall", busy, 0);
    chk("result_hold", result, m[9:2]);
  endtask

  initial begin
    int dn;
    int prev_k;
    logic prev_done;
    rst = 1'b1;
    start = 1'b0;
    op = 3'd0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd0, 8'h7F, 8'h01, -1);
    run_op(3'd1, 8'h05, 8'h07, -1);
    run_op(3'd1, 8'h3C, 8'h3C, -1);
    run_op(3'd2, 8'h0F, 8'h00, -1);
    run_op(3'd7, 8'hFF, 8'h0F, -1);
    run_op(3'd4, 8'hA0, 8'h05, -1);
    run_op(3'd0, 8'hFF, 8'h01, -1);
    run_op(3'd1, 8'h80, 8'h01, -1);

    run_op(3'd0, 8'h21, 8'h13, 2);
    run_op(3'd6, 8'hC3, 8'h5A, 6);

    // reset while bit 3 is in the slice
    op = 3'd0;
    a = 8'h55;
    b = 8'h22;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_cout", cout, 0);
    @(negedge clk);
    run_op(3'd0, 8'h55, 8'h22, -1);

    // start held high: accepted every W+2 cycles
    op = 3'd0;
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    dn = 0;
    prev_k = -1;
    prev_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        dn++;
        chk("b2b_result", result, 8'h46);
        chk("b2b_width", prev_done, 0);
        if (prev_k >= 0) chk("b2b_period", k - prev_k, W + 2);
        else chk("b2b_first", k, W);
        prev_k = k;
      end
      prev_done = done;
    end
    start = 1'b0;
    chk("b2b_count", dn, 4);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle", busy, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), 8'($urandom), 8'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_bitserial_seq.md
# alu_bitserial_seq

Bit-serial execute unit wrapped around one instance of the 1-bit ALU slice. Accepts a W-bit opcode/operand pair on a start pulse, feeds the slice one bit per cycle LSB-first, recirculates the slice carry-out as the next cycle's carry-in, and assembles the W-bit result with carry, overflow and zero flags. Sits in the execute stage in place of a W-slice ripple ALU, trading latency for area; the decode stage drives it and writeback consumes its result on `done`.

## Interface
- `W`, 8, operand/result width; W ≥ 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  slice function code; 000 add, 001 a+~b+1 (subtract), 010 ~a, 011 ~b, 100 or, 101 a|~b, 110 and, 111 a&~b.
- `a`  in  W  operand A; captured with `start`.
- `b`  in  W  operand B; captured with `start`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse, result and flags valid.
- `result`  out  W  result; holds until the next accepted `start` or reset.
- `cout`  out  1  final slice carry-out for op 000/001; 0 for logic ops.
- `ovf`  out  1  signed overflow for op 000/001 (carry into MSB xor carry out of MSB); 0 for logic ops.
- `zero`  out  1  `result == 0`.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: `start`=1 → latch `op`, `a`, `b` into shift registers; bit counter = 0; carry register = 1 if op == 001, else 0; clear `result`; go RUN.
- RUN: slice inputs = {op_r, a_sh[0], b_sh[0], carry_r}. Each cycle: a_sh, b_sh shift right 1; slice `f` shifts into `result` MSB (result shifts right); carry_r ← slice `co`; counter increments. On the cycle counter == W-1: capture carry_r_before (carry into MSB) and slice `co`; go DONE.
- DONE: `done`=1 for exactly one cycle; `cout`, `ovf`, `zero` valid; go IDLE.
- Logic ops run the same W cycles; carry chain still runs internally but `cout`/`ovf` are forced to 0.
- `start` in RUN or DONE is ignored (no queueing); the upstream stage holds the request until `busy`=0.
- `start` in the same cycle DONE→IDLE transition completes is not seen; it is sampled next cycle in IDLE.
- Operand inputs may change freely after the accepting cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `cout`=0, `ovf`=0, `zero`=0 (zero is registered, not combinational, so it is 0 after reset); state IDLE; counter 0; carry_r 0.
- Reset mid-operation aborts immediately: next cycle in IDLE, all outputs at reset values.
- Latency: `start` accepted at cycle t → bit i processed at t+1+i → `done` high at cycle t+W+1. Throughput: one operation per W+2 cycles.
- `busy` rises at t+1, falls at t+W+2.
- Counter width $clog2(W); no wrap beyond W-1.

## Structure
- Shared package: opcode constants (OP_ADD=000 … OP_ANDN=111), state enum, `is_arith(op)` helper (op[2:1]==00).
- One sub-module: `ALUslice`, instantiated once; the sequencer contains the FSM, shift registers, counter and flag logic.

## Test plan
- W=8, op 000, a=7F, b=01 → `done` at t+9, result=80, cout=0, ovf=1, zero=0.
- op 001, a=05, b=07 → result=FE, cout=0 (borrow), ovf=0; op 001, a=3C, b=3C → result=00, cout=1, zero=1.
- op 010, a=0F → result=F0; op 111, a=FF, b=0F → result=F0, cout=0, ovf=0; op 100, a=A0, b=05 → result=A5.
- `start` pulsed during RUN with different operands → ignored; first op's result unchanged, single `done` pulse.
- `rst` asserted at bit 3 of an add → next cycle IDLE, busy=0, result=00; a new start afterwards completes normally with correct result.
- Back-to-back: `start` held high continuously → operations accepted every 10 cycles, each `done` one cycle wide.
